pipeline_hazard_controller: RTL

Central stall/flush sequencer for the five-stage pipeline. Watches decode-stage sources, the ID/EX and EX/MEM control bits, the data-memory busy handshake and halt, then drives the write-enable and bubble-insert controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Also keeps a saturating stall-cycle counter and a memory-timeout watchdog.

---
 rtl/pipeline_hazard_controller.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: freezes on data-memory waits,
// bubbles load-use hazards, flushes taken branches, drains on halt, and watches memory timeouts.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  idRs,
  input  logic [2:0]  idRt,
  input  logic        idUsesRs,
  input  logic        idUsesRt,
  input  logic        idHalt,
  input  logic        exMemoryRead,
  input  logic        exRegisterWrite,
  input  logic [2:0]  exWriteRegister,
  input  logic        branchTaken,
  input  logic        memAccess,
  input  logic        memStall,
  input  logic        memDone,
  input  logic        wbHalt,
  output logic        pcWriteEnable,
  output logic        ifIdWriteEnable,
  output logic        idExWriteEnable,
  output logic        exMemWriteEnable,
  output logic        memWbWriteEnable,
  output logic        ifIdFlush,
  output logic        idExFlush,
  output logic        memWbFlush,
  output logic [1:0]  state,
  output logic        halted,
  output logic        memError,
  output logic [15:0] stallCycles
);
  typedef enum logic [1:0] {RUN = 2'd0, MEMWAIT = 2'd1, DRAIN = 2'd2, HALTED = 2'd3} stateT;
  typedef enum logic [1:0] {ACT_RUN, ACT_FREEZE, ACT_DRAIN, ACT_IDLE} actionT;

  stateT       stateReg, stateNext;
  actionT      action;
  logic [7:0]  waitReg, waitNext;
  logic        resumeDrainReg, resumeDrainNext;
  logic        memErrorReg, memErrorNext;
  logic [15:0] stallReg;
  logic        loadUse, memBusy, haltSelected;

  assign loadUse = exMemoryRead & exRegisterWrite &
                   ((idUsesRs & (idRs == exWriteRegister)) | (idUsesRt & (idRt == exWriteRegister)));
  assign memBusy = memAccess & memStall & ~memDone;
  assign haltSelected = idHalt & ~branchTaken & ~loadUse;

  // Decide what this cycle does and where the sequencer goes next.
  always_comb begin
    action          = ACT_IDLE;
    stateNext       = stateReg;
    waitNext        = waitReg;
    resumeDrainNext = resumeDrainReg;
    memErrorNext    = memErrorReg;
    case (stateReg)
      RUN, DRAIN: begin
        if (memBusy) begin
          action          = ACT_FREEZE;
          stateNext       = MEMWAIT;
          waitNext        = 8'd1;
          resumeDrainNext = (stateReg == DRAIN);
        end else if (stateReg == DRAIN) begin
          action = ACT_DRAIN;
        end else begin
          action    = ACT_RUN;
          stateNext = haltSelected ? DRAIN : RUN;
        end
      end
      MEMWAIT: begin
        if (!memDone) begin
          action = ACT_FREEZE;
          if (waitReg == 8'(MEM_TIMEOUT)) begin
            memErrorNext = 1'b1;
            stateNext    = HALTED;
          end else begin
            waitNext = waitReg + 8'd1;
          end
        end else if (resumeDrainReg) begin
          action    = ACT_DRAIN;
          stateNext = DRAIN;
        end else begin
          action    = ACT_RUN;
          stateNext = haltSelected ? DRAIN : RUN;
        end
      end
      default: action = ACT_IDLE;
    endcase
    // A halt reaching writeback retires the machine regardless of anything younger.
    if (wbHalt && stateReg != HALTED) stateNext = HALTED;
  end

  always_comb begin
    {pcWriteEnable, ifIdWriteEnable, idExWriteEnable, exMemWriteEnable, memWbWriteEnable} = 5'b11111;
    {ifIdFlush, idExFlush, memWbFlush} = 3'b000;
    case (action)
      ACT_FREEZE: begin
        {pcWriteEnable, ifIdWriteEnable, idExWriteEnable, exMemWriteEnable, memWbWriteEnable} = 5'b00000;
        memWbFlush = 1'b1;
      end
      ACT_DRAIN: begin
        pcWriteEnable   = 1'b0;
        ifIdWriteEnable = 1'b0;
        idExFlush       = 1'b1;
      end
      ACT_IDLE: begin
        {pcWriteEnable, ifIdWriteEnable, idExWriteEnable, exMemWriteEnable, memWbWriteEnable} = 5'b00000;
      end
      default: begin
        if (branchTaken) begin
          ifIdFlush = 1'b1;
          idExFlush = 1'b1;
        end else if (loadUse) begin
          pcWriteEnable   = 1'b0;
          ifIdWriteEnable = 1'b0;
          idExFlush       = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg       <= RUN;
      waitReg        <= 8'd0;
      resumeDrainReg <= 1'b0;
      memErrorReg    <= 1'b0;
      stallReg       <= 16'd0;
    end else begin
      stateReg       <= stateNext;
      waitReg        <= waitNext;
      resumeDrainReg <= resumeDrainNext;
      memErrorReg    <= memErrorNext;
      if (!pcWriteEnable && stateReg != HALTED && stallReg != 16'hFFFF)
        stallReg <= stallReg + 16'd1;
    end
  end

  assign state       = stateReg;
  assign halted      = (stateReg == HALTED);
  assign memError    = memErrorReg;
  assign stallCycles = stallReg;
endmodule
